// File: rtl/mc_controller.sv
// ---------------------------------------------------------------------------
// mc_controller
// Multicycle MIPS control unit. A Moore FSM walks one instruction at a time
// through fetch, decode, execute, memory and writeback. It drives every
// datapath select, enable and ALU control code.
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset (0 = in reset)
//   op, funct  : instruction[31:26] and instruction[5:0] from the IR
//   zero       : ALU zero flag, used for beq
//   memready   : memory finished the current access this cycle
//   pcen       : PC enable (fetch advance, taken beq, jump)
//   iord       : memory address select (0 = PC, 1 = ALUOut)
//   memwrite   : memory write strobe
//   irwrite    : instruction register enable
//   regdst     : write register select (0 = rt, 1 = rd)
//   memtoreg   : writeback select (0 = ALUOut, 1 = Data)
//   regwrite   : register file write enable
//   alusrca    : ALU A select (0 = PC, 1 = register A)
//   alusrcb    : ALU B select (00 B, 01 +4, 10 imm, 11 imm<<2)
//   pcsrc      : PC source (00 ALU result, 01 ALUOut, 10 jump target)
//   zeroext    : zero-extend the immediate (xori)
//   alucontrol : ALU function code
//   state      : current FSM state, exported for debug
// ---------------------------------------------------------------------------
module mc_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       zeroext,
  output logic [3:0] alucontrol,
  output logic [3:0] state
);

  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] RTYPEEX = 4'd6;
  localparam logic [3:0] RTYPEWB = 4'd7;
  localparam logic [3:0] BEQEX   = 4'd8;
  localparam logic [3:0] ADDIEX  = 4'd9;
  localparam logic [3:0] ITYPEWB = 4'd10;
  localparam logic [3:0] JEX     = 4'd11;
  localparam logic [3:0] XORIEX  = 4'd12;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [3:0] state_r;
  logic [3:0] next_state_s;
  logic       pcen_s;
  logic       memwrite_s;
  logic       irwrite_s;
  logic       regwrite_s;
  logic [4:0] rtype_s;

  // R-type funct decode: {legal, alucontrol}. Unknown funct keeps the add
  // code on the ALU and is flagged illegal so no writeback follows.
  function automatic logic [4:0] rtype_decode(input logic [5:0] f);
    case (f)
      6'b100000: return {1'b1, 4'b0010};
      6'b100010: return {1'b1, 4'b1010};
      6'b100100: return {1'b1, 4'b0000};
      6'b100101: return {1'b1, 4'b0001};
      6'b101010: return {1'b1, 4'b1011};
      6'b000110: return {1'b1, 4'b0100};
      default:   return {1'b0, 4'b0010};
    endcase
  endfunction

  assign rtype_s = rtype_decode(funct);

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= RESET_STATE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; memready only matters in FETCH, MEMRD and MEMWR.
  always_comb begin
    next_state_s = FETCH;
    case (state_r)
      FETCH:   next_state_s = memready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state_s = MEMADR;
          OP_RTYPE:     next_state_s = RTYPEEX;
          OP_BEQ:       next_state_s = BEQEX;
          OP_ADDI:      next_state_s = ADDIEX;
          OP_XORI:      next_state_s = XORIEX;
          OP_J:         next_state_s = JEX;
          default:      next_state_s = FETCH;
        endcase
      end
      MEMADR:  next_state_s = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   next_state_s = memready ? MEMWB : MEMRD;
      MEMWB:   next_state_s = FETCH;
      MEMWR:   next_state_s = memready ? FETCH : MEMWR;
      RTYPEEX: next_state_s = rtype_s[4] ? RTYPEWB : FETCH;
      RTYPEWB: next_state_s = FETCH;
      BEQEX:   next_state_s = FETCH;
      ADDIEX:  next_state_s = ITYPEWB;
      ITYPEWB: next_state_s = FETCH;
      JEX:     next_state_s = FETCH;
      XORIEX:  next_state_s = ITYPEWB;
      default: next_state_s = FETCH;
    endcase
  end

  // Moore output decode; only pcen and irwrite look at memready/zero.
  always_comb begin
    pcen_s     = 1'b0;
    iord       = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite_s = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    zeroext    = 1'b0;
    alucontrol = 4'b0000;
    case (state_r)
      FETCH: begin
        alusrcb    = 2'b01;
        alucontrol = 4'b0010;
        irwrite_s  = memready;
        pcen_s     = memready;
      end
      DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = 4'b0010;
      end
      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = 4'b0010;
      end
      MEMRD: begin
        iord = 1'b1;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = rtype_s[3:0];
      end
      RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
      end
      BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = 4'b1010;
        pcsrc      = 2'b01;
        pcen_s     = zero;
      end
      ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = 4'b0010;
      end
      ITYPEWB: begin
        regwrite_s = 1'b1;
      end
      JEX: begin
        pcsrc  = 2'b10;
        pcen_s = 1'b1;
      end
      XORIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        zeroext    = 1'b1;
        alucontrol = 4'b0101;
      end
      default: begin
        pcen_s = 1'b0;
      end
    endcase
  end

  // Write enables are forced low combinationally while reset is held, so an
  // aborted instruction cannot leave a strobe pulsing before the next edge.
  assign pcen     = pcen_s & reset;
  assign irwrite  = irwrite_s & reset;
  assign memwrite = memwrite_s & reset;
  assign regwrite = regwrite_s & reset;
  assign state    = state_r;

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memready;
  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, zeroext;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] alucontrol, state;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
    .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .zeroext(zeroext), .alucontrol(alucontrol), .state(state)
  );

  // Expected vector layout: {state, en[7:0], alusrcb, pcsrc, zeroext, alucontrol}
  // en = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca}
  localparam logic [20:0] E_FETCH1 = {4'd0,  8'b1001_0000, 2'b01, 2'b00, 1'b0, 4'b0010};
  localparam logic [20:0] E_FETCH0 = {4'd0,  8'b0000_0000, 2'b01, 2'b00, 1'b0, 4'b0010};
  localparam logic [20:0] E_DECODE = {4'd1,  8'b0000_0000, 2'b11, 2'b00, 1'b0, 4'b0010};
  localparam logic [20:0] E_MEMADR = {4'd2,  8'b0000_0001, 2'b10, 2'b00, 1'b0, 4'b0010};
  localparam logic [20:0] E_MEMRD  = {4'd3,  8'b0100_0000, 2'b00, 2'b00, 1'b0, 4'b0000};
  localparam logic [20:0] E_MEMWB  = {4'd4,  8'b0000_0110, 2'b00, 2'b00, 1'b0, 4'b0000};
  localparam logic [20:0] E_MEMWR  = {4'd5,  8'b0110_0000, 2'b00, 2'b00, 1'b0, 4'b0000};
  localparam logic [20:0] E_RTWB   = {4'd7,  8'b0000_1010, 2'b00, 2'b00, 1'b0, 4'b0000};
  localparam logic [20:0] E_BEQ1   = {4'd8,  8'b1000_0001, 2'b00, 2'b01, 1'b0, 4'b1010};
  localparam logic [20:0] E_BEQ0   = {4'd8,  8'b0000_0001, 2'b00, 2'b01, 1'b0, 4'b1010};
  localparam logic [20:0] E_ADDI   = {4'd9,  8'b0000_0001, 2'b10, 2'b00, 1'b0, 4'b0010};
  localparam logic [20:0] E_ITWB   = {4'd10, 8'b0000_0010, 2'b00, 2'b00, 1'b0, 4'b0000};
  localparam logic [20:0] E_J      = {4'd11, 8'b1000_0000, 2'b00, 2'b10, 1'b0, 4'b0000};
  localparam logic [20:0] E_XORI   = {4'd12, 8'b0000_0001, 2'b10, 2'b00, 1'b1, 4'b0101};

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, XORI = 6'b001110, JMP = 6'b000010, BAD = 6'b111111;

  logic [5:0] fn_tab [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000110};
  logic [3:0] ac_tab [6] = '{4'b0010, 4'b1010, 4'b0000, 4'b0001, 4'b1011, 4'b0100};

  logic [20:0] exp_q [$];
  int          tag_q [$];
  int          step_no  = 0;
  int          checks   = 0;
  int          failures = 0;
  event        sample_ev;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs just after the rising edge and queue the
  // outputs expected for that cycle.
  task automatic step(input logic rst, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input logic mr, input logic [20:0] e);
    @(posedge clk);
    #1;
    reset = rst; op = o; funct = f; zero = z; memready = mr;
    exp_q.push_back(e);
    tag_q.push_back(step_no);
    step_no++;
  endtask

  // Monitor: sample mid-cycle (or on an explicit request) and compare.
  initial begin
    logic [20:0] got;
    logic [20:0] e;
    int          t;
    forever begin
      @(negedge clk or sample_ev);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        got = {state, pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
               alusrcb, pcsrc, zeroext, alucontrol};
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL step%0d outputs: got state=%0d en=%b b=%b pcsrc=%b zx=%b alu=%b, exp state=%0d en=%b b=%b pcsrc=%b zx=%b alu=%b",
                   t, got[20:17], got[16:9], got[8:7], got[6:5], got[4], got[3:0],
                   e[20:17], e[16:9], e[8:7], e[6:5], e[4], e[3:0]);
        end
      end
    end
  end

  initial begin
    int guard;
    reset = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; memready = 1'b0;

    // Held in reset: FETCH values, enables low even with memready=1
    step(1'b0, BAD, 6'd0, 1'b0, 1'b1, E_FETCH0);
    step(1'b0, BAD, 6'd0, 1'b0, 1'b1, E_FETCH0);

    // lw with a one-cycle fetch stall and a one-cycle MEMRD stall
    step(1'b1, LW, 6'd0, 1'b0, 1'b0, E_FETCH0);
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, E_FETCH1);
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, E_DECODE);
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, E_MEMADR);
    step(1'b1, LW, 6'd0, 1'b0, 1'b0, E_MEMRD);
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, E_MEMRD);
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, E_MEMWB);

    // sw with three memready=0 cycles in MEMWR
    step(1'b1, SW, 6'd0, 1'b0, 1'b1, E_FETCH1);
    step(1'b1, SW, 6'd0, 1'b0, 1'b1, E_DECODE);
    step(1'b1, SW, 6'd0, 1'b0, 1'b0, E_MEMADR);
    step(1'b1, SW, 6'd0, 1'b0, 1'b0, E_MEMWR);
    step(1'b1, SW, 6'd0, 1'b0, 1'b0, E_MEMWR);
    step(1'b1, SW, 6'd0, 1'b0, 1'b0, E_MEMWR);
    step(1'b1, SW, 6'd0, 1'b0, 1'b1, E_MEMWR);

    // R-type funct sweep
    for (int i = 0; i < 6; i++) begin
      step(1'b1, RT, fn_tab[i], 1'b0, 1'b1, E_FETCH1);
      step(1'b1, RT, fn_tab[i], 1'b0, 1'b1, E_DECODE);
      step(1'b1, RT, fn_tab[i], 1'b0, 1'b1, {4'd6, 8'b0000_0001, 2'b00, 2'b00, 1'b0, ac_tab[i]});
      step(1'b1, RT, fn_tab[i], 1'b0, 1'b1, E_RTWB);
    end

    // Unknown funct: execute then straight back to FETCH, no writeback
    step(1'b1, RT, BAD, 1'b0, 1'b1, E_FETCH1);
    step(1'b1, RT, BAD, 1'b0, 1'b1, E_DECODE);
    step(1'b1, RT, BAD, 1'b0, 1'b1, {4'd6, 8'b0000_0001, 2'b00, 2'b00, 1'b0, 4'b0010});

    // beq taken then not taken
    step(1'b1, BEQ, 6'd0, 1'b1, 1'b1, E_FETCH1);
    step(1'b1, BEQ, 6'd0, 1'b1, 1'b1, E_DECODE);
    step(1'b1, BEQ, 6'd0, 1'b1, 1'b1, E_BEQ1);
    step(1'b1, BEQ, 6'd0, 1'b0, 1'b1, E_FETCH1);
    step(1'b1, BEQ, 6'd0, 1'b0, 1'b1, E_DECODE);
    step(1'b1, BEQ, 6'd0, 1'b0, 1'b1, E_BEQ0);

    // addi, xori, j, illegal op
    step(1'b1, ADDI, 6'd0, 1'b0, 1'b1, E_FETCH1);
    step(1'b1, ADDI, 6'd0, 1'b0, 1'b1, E_DECODE);
    step(1'b1, ADDI, 6'd0, 1'b0, 1'b1, E_ADDI);
    step(1'b1, XORI, 6'd0, 1'b0, 1'b1, E_ITWB);
    step(1'b1, XORI, 6'd0, 1'b0, 1'b1, E_FETCH1);
    step(1'b1, XORI, 6'd0, 1'b0, 1'b1, E_DECODE);
    step(1'b1, XORI, 6'd0, 1'b0, 1'b1, E_XORI);
    step(1'b1, JMP, 6'd0, 1'b0, 1'b1, E_ITWB);
    step(1'b1, JMP, 6'd0, 1'b0, 1'b1, E_FETCH1);
    step(1'b1, JMP, 6'd0, 1'b0, 1'b1, E_DECODE);
    step(1'b1, BAD, 6'd0, 1'b0, 1'b1, E_J);
    step(1'b1, BAD, 6'd0, 1'b0, 1'b1, E_FETCH1);
    step(1'b1, BAD, 6'd0, 1'b0, 1'b1, E_DECODE);
    step(1'b1, RT, 6'b100000, 1'b0, 1'b1, E_FETCH1);

    // Reset asserted mid-RTYPEWB, checked before any further clock edge
    step(1'b1, RT, 6'b100000, 1'b0, 1'b1, E_DECODE);
    step(1'b1, RT, 6'b100000, 1'b0, 1'b1, {4'd6, 8'b0000_0001, 2'b00, 2'b00, 1'b0, 4'b0010});
    step(1'b1, RT, 6'b100000, 1'b0, 1'b1, E_RTWB);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    exp_q.push_back(E_FETCH0);
    tag_q.push_back(step_no);
    step_no++;
    -> sample_ev;
    step(1'b0, BAD, 6'd0, 1'b0, 1'b1, E_FETCH0);
    step(1'b1, BAD, 6'd0, 1'b0, 1'b1, E_FETCH1);
    step(1'b1, BAD, 6'd0, 1'b0, 1'b1, E_DECODE);
    step(1'b1, BAD, 6'd0, 1'b0, 1'b1, E_FETCH1);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
